// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the microwave cook timer: state encoding,
// BCD time record, segment patterns and the 99:59 ceiling.
`timescale 1ns/1ps
package cook_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [3:0] min_d1;
        logic [3:0] min_d0;
        logic [3:0] sec_d1;
        logic [3:0] sec_d0;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = 16'h0000;
    localparam bcd_time_t TIME_MAX  = 16'h9959;

    // Active-low segments, bit order gfedcba.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/cook_timer_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes blank
// the digit rather than showing garbage.
`timescale 1ns/1ps
module seg7_decode
    import cook_timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup for one digit.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave countdown core: MM:SS held as BCD, key handling, door interlock,
// one-second prescaler and completion pulse.
`timescale 1ns/1ps
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int QUICK_SEC10 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       add_min,
    input  logic       add_sec10,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic [3:0] min_d1,
    output logic [3:0] min_d0,
    output logic [3:0] sec_d1,
    output logic [3:0] sec_d0,
    output logic [6:0] display_min_D1,
    output logic [6:0] display_min_D0,
    output logic [6:0] display_sec_D1,
    output logic [6:0] display_sec_D0,
    output logic [2:0] state,
    output logic       magnetron_on,
    output logic       done
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam bcd_time_t       QUICK_TIME = {4'd0, 4'd0, 4'(QUICK_SEC10), 4'd0};

    function automatic logic minutes_full(input bcd_time_t t);
        return (t.min_d1 == TIME_MAX.min_d1) && (t.min_d0 == TIME_MAX.min_d0);
    endfunction

    function automatic bcd_time_t inc_min(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (minutes_full(t)) begin
            r = t;
        end else if (t.min_d0 == 4'd9) begin
            r.min_d0 = 4'd0;
            r.min_d1 = t.min_d1 + 4'd1;
        end else begin
            r.min_d0 = t.min_d0 + 4'd1;
        end
        return r;
    endfunction

    // A 5->0 wrap of the tens-of-seconds needs a free minute, else no change.
    function automatic bcd_time_t inc_sec10(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_d1 == 4'd5) begin
            if (minutes_full(t)) begin
                r = t;
            end else begin
                r        = inc_min(t);
                r.sec_d1 = 4'd0;
            end
        end else begin
            r.sec_d1 = t.sec_d1 + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t dec_sec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_d0 != 4'd0) begin
            r.sec_d0 = t.sec_d0 - 4'd1;
        end else if (t.sec_d1 != 4'd0) begin
            r.sec_d0 = 4'd9;
            r.sec_d1 = t.sec_d1 - 4'd1;
        end else if (t.min_d0 != 4'd0) begin
            r.sec_d0 = 4'd9;
            r.sec_d1 = 4'd5;
            r.min_d0 = t.min_d0 - 4'd1;
        end else begin
            r.sec_d0 = 4'd9;
            r.sec_d1 = 4'd5;
            r.min_d0 = 4'd9;
            r.min_d1 = t.min_d1 - 4'd1;
        end
        return r;
    endfunction

    state_e         state_r, state_s;
    bcd_time_t      time_r, time_s;
    logic [PW-1:0]  presc_r, presc_s;
    logic           done_r, magnetron_r;
    logic           add_s, start_ok_s, tick_s;
    bcd_time_t      add_time_s, dec_time_s;

    assign add_s      = add_min | add_sec10;
    assign start_ok_s = start & ~door_open;
    assign tick_s     = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
    assign add_time_s = add_min ? inc_min(time_r) : inc_sec10(time_r);
    assign dec_time_s = dec_sec(time_r);

    // Next state, next time and next prescaler value; one key action per cycle by priority.
    always_comb begin
        state_s = state_r;
        time_s  = time_r;
        presc_s = presc_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    time_s  = TIME_ZERO;
                end else if (start_ok_s) begin
                    state_s = ST_RUN;
                    time_s  = QUICK_TIME;
                end else if (add_s) begin
                    state_s = ST_SET;
                    time_s  = add_time_s;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SET, ST_PAUSE: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    time_s  = TIME_ZERO;
                end else if (start_ok_s) begin
                    state_s = ST_RUN;
                end else if (add_s) begin
                    time_s = add_time_s;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (stop || door_open) begin
                    state_s = ST_PAUSE;
                end else if (add_s) begin
                    time_s = add_time_s;
                end else if (tick_s) begin
                    time_s = dec_time_s;
                    if (dec_time_s == TIME_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                time_s  = TIME_ZERO;
            end
        endcase

        // An add that lands on the tick cycle wins; the tick is retried next cycle.
        if ((state_s == ST_RUN) && (state_r != ST_RUN)) begin
            presc_s = '0;
        end else if (state_r == ST_RUN) begin
            if (tick_s && add_s) begin
                presc_s = presc_r;
            end else if (tick_s) begin
                presc_s = '0;
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = '0;
        end
    end

    // Registered state, time, prescaler and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            time_r      <= TIME_ZERO;
            presc_r     <= '0;
            done_r      <= 1'b0;
            magnetron_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            time_r      <= time_s;
            presc_r     <= presc_s;
            done_r      <= (state_s == ST_DONE) && (state_r != ST_DONE);
            magnetron_r <= (state_s == ST_RUN);
        end
    end

    assign state        = state_r;
    assign min_d1       = time_r.min_d1;
    assign min_d0       = time_r.min_d0;
    assign sec_d1       = time_r.sec_d1;
    assign sec_d0       = time_r.sec_d0;
    assign magnetron_on = magnetron_r;
    assign done         = done_r;

    seg7_decode u_seg_min_d1 (.bcd(time_r.min_d1), .seg(display_min_D1));
    seg7_decode u_seg_min_d0 (.bcd(time_r.min_d0), .seg(display_min_D0));
    seg7_decode u_seg_sec_d1 (.bcd(time_r.sec_d1), .seg(display_sec_D1));
    seg7_decode u_seg_sec_d0 (.bcd(time_r.sec_d0), .seg(display_sec_D0));

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer: a seconds-based reference model checked every
// cycle, plus literal expectations at the scenario checkpoints.
`timescale 1ns/1ps
module tb_cook_timer;

    localparam int TICK_DIV    = 4;
    localparam int QUICK_SEC10 = 3;
    localparam int MAX_SECONDS = 99 * 60 + 59;

    logic       clk = 1'b0;
    logic       reset, add_min, add_sec10, start, stop, door_open;
    logic [3:0] min_d1, min_d0, sec_d1, sec_d0;
    logic [6:0] display_min_D1, display_min_D0, display_sec_D1, display_sec_D0;
    logic [2:0] state;
    logic       magnetron_on, done;

    int errs   = 0;
    int checks = 0;
    int done_cnt = 0;
    int d_snap;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cook_timer #(.TICK_DIV(TICK_DIV), .QUICK_SEC10(QUICK_SEC10)) dut (
        .clk(clk), .reset(reset), .add_min(add_min), .add_sec10(add_sec10),
        .start(start), .stop(stop), .door_open(door_open),
        .min_d1(min_d1), .min_d0(min_d0), .sec_d1(sec_d1), .sec_d0(sec_d0),
        .display_min_D1(display_min_D1), .display_min_D0(display_min_D0),
        .display_sec_D1(display_sec_D1), .display_sec_D0(display_sec_D0),
        .state(state), .magnetron_on(magnetron_on), .done(done)
    );

    // Model: state number (0 IDLE,1 SET,2 RUN,3 PAUSE,4 DONE), time in plain seconds,
    // cycles spent in RUN since the last tick, and the completion pulse.
    typedef struct packed {
        int   st;
        int   t;
        int   cnt;
        logic dn;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t step(input mdl_t m, input logic rs, input logic am,
                                  input logic as10, input logic go, input logic sp,
                                  input logic dr);
        mdl_t n;
        int   inc;
        logic tick, add_in_run;
        n = m;
        add_in_run = 1'b0;
        tick = (m.st == 2) && (m.cnt == TICK_DIV - 1);
        if (rs) begin
            n.st = 0; n.t = 0; n.cnt = 0; n.dn = 1'b0;
            return n;
        end
        if (sp) begin
            if (m.st == 2) n.st = 3;
            else begin n.st = 0; n.t = 0; end
        end else if (dr && m.st == 2) begin
            n.st = 3;
        end else if (go && !dr && m.st != 2) begin
            if (m.st == 0 || m.st == 4) n.t = QUICK_SEC10 * 10;
            n.st = 2;
        end else if (am || as10) begin
            inc = am ? 60 : 10;
            if (m.t + inc <= MAX_SECONDS) n.t = m.t + inc;
            if (m.st == 0 || m.st == 4) n.st = 1;
            add_in_run = (m.st == 2);
        end else if (tick) begin
            n.t = m.t - 1;
            if (n.t == 0) n.st = 4;
        end
        if (n.st == 2 && m.st != 2) n.cnt = 0;
        else if (m.st == 2 && n.st == 2) n.cnt = (tick && add_in_run) ? m.cnt : (tick ? 0 : m.cnt + 1);
        else n.cnt = 0;
        n.dn = (n.st == 4) && (m.st != 4);
        return n;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] bcd_of(input int t);
        int mins, secs;
        mins = t / 60;
        secs = t % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) mdl <= step(mdl, reset, add_min, add_sec10, start, stop, door_open);

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs",
                  64'({state, min_d1, min_d0, sec_d1, sec_d0, magnetron_on, done}),
                  64'({3'(mdl.st), bcd_of(mdl.t), (mdl.st == 2), mdl.dn}));
            check("segments",
                  64'({display_min_D1, display_min_D0, display_sec_D1, display_sec_D0}),
                  64'({seg_of(mdl.t / 600), seg_of((mdl.t / 60) % 10),
                       seg_of((mdl.t % 60) / 10), seg_of(mdl.t % 10)}));
        end
    end

    function automatic logic [15:0] dut_time();
        return {min_d1, min_d0, sec_d1, sec_d0};
    endfunction

    initial begin
        reset = 1'b1; add_min = 1'b0; add_sec10 = 1'b0;
        start = 1'b0; stop = 1'b0; door_open = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        reset  = 1'b0;
        repeat (10) cyc();
        check("reset_state", 64'(state), 64'(3'd0));
        check("reset_time", 64'(dut_time()), 64'(16'h0000));
        check("reset_segs", 64'({display_min_D1, display_min_D0, display_sec_D1, display_sec_D0}),
              64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));
        check("reset_mag", 64'(magnetron_on), 64'(1'b0));

        // 01:20 countdown by sixty seconds
        d_snap = done_cnt;
        add_min = 1'b1; cyc(); add_min = 1'b0;
        add_sec10 = 1'b1; cyc(); cyc(); add_sec10 = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        check("set_0120", 64'(dut_time()), 64'(16'h0120));
        check("run_state", 64'(state), 64'(3'd2));
        repeat (60 * TICK_DIV) cyc();
        check("after_60_ticks", 64'(dut_time()), 64'(16'h0020));
        check("no_done", 64'(done_cnt - d_snap), 64'(0));
        stop = 1'b1; cyc(); cyc(); stop = 1'b0;
        check("stop_twice_idle", 64'({state, dut_time()}), 64'({3'd0, 16'h0000}));

        // Quick start to completion
        d_snap = done_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        check("quick_0030", 64'({state, dut_time()}), 64'({3'd2, 16'h0030}));
        repeat (30 * TICK_DIV) cyc();
        check("done_state", 64'({state, dut_time(), done}), 64'({3'd4, 16'h0000, 1'b1}));
        cyc();
        check("done_drop", 64'({done, magnetron_on}), 64'({1'b0, 1'b0}));
        check("done_once", 64'(done_cnt - d_snap), 64'(1));

        // Door interlock at 00:17
        stop = 1'b1; cyc(); stop = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (13 * TICK_DIV) cyc();
        check("at_0017", 64'(dut_time()), 64'(16'h0017));
        door_open = 1'b1; cyc();
        check("door_pause", 64'({state, dut_time(), magnetron_on}), 64'({3'd3, 16'h0017, 1'b0}));
        start = 1'b1; cyc(); start = 1'b0;
        check("start_door_open", 64'({state, dut_time()}), 64'({3'd3, 16'h0017}));
        door_open = 1'b0; cyc();
        start = 1'b1; cyc(); start = 1'b0;
        check("resume", 64'({state, magnetron_on}), 64'({3'd2, 1'b1}));
        repeat (TICK_DIV) cyc();
        check("resume_count", 64'(dut_time()), 64'(16'h0016));

        // add_min landing on a tick at 00:05
        repeat (11 * TICK_DIV + TICK_DIV - 1) cyc();
        check("at_0005", 64'(dut_time()), 64'(16'h0005));
        add_min = 1'b1; cyc(); add_min = 1'b0;
        check("add_on_tick", 64'(dut_time()), 64'(16'h0105));
        cyc();
        check("deferred_tick", 64'(dut_time()), 64'(16'h0104));
        stop = 1'b1; cyc();
        check("stop_pause", 64'(state), 64'(3'd3));
        cyc(); stop = 1'b0;
        check("pause_stop_idle", 64'({state, dut_time()}), 64'({3'd0, 16'h0000}));

        // Tens-of-seconds carry into minutes
        add_sec10 = 1'b1; repeat (6) cyc(); add_sec10 = 1'b0;
        check("sec10_carry", 64'({state, dut_time()}), 64'({3'd1, 16'h0100}));
        stop = 1'b1; cyc(); stop = 1'b0;

        // Saturation at 99:59
        add_min = 1'b1; repeat (99) cyc(); add_min = 1'b0;
        add_sec10 = 1'b1; repeat (5) cyc();
        check("preload_9950", 64'(dut_time()), 64'(16'h9950));
        cyc(); add_sec10 = 1'b0;
        check("sat_sec10", 64'(dut_time()), 64'(16'h9950));
        add_min = 1'b1; cyc(); add_min = 1'b0;
        check("sat_min", 64'(dut_time()), 64'(16'h9950));
        stop = 1'b1; cyc(); stop = 1'b0;
        add_min = 1'b1; repeat (99) cyc(); add_min = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (TICK_DIV) cyc();
        check("borrow_9859", 64'(dut_time()), 64'(16'h9859));
        stop = 1'b1; cyc(); stop = 1'b0;
        add_min = 1'b1; cyc(); add_min = 1'b0;
        check("add_to_9959", 64'({state, dut_time()}), 64'({3'd3, 16'h9959}));
        add_sec10 = 1'b1; cyc(); add_sec10 = 1'b0;
        check("sat_at_max", 64'(dut_time()), 64'(16'h9959));
        stop = 1'b1; cyc(); stop = 1'b0;

        // stop with door_open in RUN, then reset mid-RUN
        start = 1'b1; cyc(); start = 1'b0;
        repeat (2) cyc();
        stop = 1'b1; door_open = 1'b1; cyc(); stop = 1'b0; door_open = 1'b0;
        check("stop_door_pause", 64'(state), 64'(3'd3));
        start = 1'b1; cyc(); start = 1'b0;
        repeat (TICK_DIV - 1) cyc();
        d_snap = done_cnt;
        reset = 1'b1; cyc(); reset = 1'b0;
        check("reset_mid_run", 64'({state, dut_time(), magnetron_on, done}),
              64'({3'd0, 16'h0000, 1'b0, 1'b0}));
        repeat (3) cyc();
        check("reset_no_done", 64'(done_cnt - d_snap), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
